// File: rtl/alu_src_pkg.sv
// rtl/alu_src_pkg.sv - shared source-select codes for the ALU operand source stage
package alu_src_pkg;

    localparam int CODE_W = 8;

    localparam logic [CODE_W-1:0] SEL_ZERO   = 8'b00010000;
    localparam logic [CODE_W-1:0] SEL_RX     = 8'b00000101;
    localparam logic [CODE_W-1:0] SEL_Z_IMM3 = 8'b00010001;
    localparam logic [CODE_W-1:0] SEL_Z_IMM8 = 8'b00010010;
    localparam logic [CODE_W-1:0] SEL_IN     = 8'b00001000;
    localparam logic [CODE_W-1:0] SEL_SP     = 8'b00001001;
    localparam logic [CODE_W-1:0] SEL_T      = 8'b00001010;
    localparam logic [CODE_W-1:0] SEL_PC     = 8'b00010011;

endpackage

// File: rtl/alu_fwd_unit.sv
// rtl/alu_fwd_unit.sv - EX/MEM writeback bypass for the RX operand (EX has priority)
module alu_fwd_unit #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 3
) (
    input  logic             en,
    input  logic             ex_wr_en,
    input  logic [IDX_W-1:0] ex_wr_idx,
    input  logic [WIDTH-1:0] ex_wr_data,
    input  logic             mem_wr_en,
    input  logic [IDX_W-1:0] mem_wr_idx,
    input  logic [WIDTH-1:0] mem_wr_data,
    input  logic [IDX_W-1:0] rx_idx,
    input  logic [WIDTH-1:0] data_rx,
    output logic [WIDTH-1:0] rx_val
);

    logic ex_hit;
    logic mem_hit;

    assign ex_hit  = en && ex_wr_en  && (ex_wr_idx  == rx_idx);
    assign mem_hit = en && mem_wr_en && (mem_wr_idx == rx_idx);

    always_comb begin
        rx_val = data_rx;
        if (mem_hit) rx_val = mem_wr_data;
        // EX is the younger write, so it overrides MEM
        if (ex_hit)  rx_val = ex_wr_data;
    end

endmodule

// File: rtl/alu_src_stage.sv
// rtl/alu_src_stage.sv - operand source select + output register; RX bypass enabled by ALU_SRC_FWD_EN
module alu_src_stage
    import alu_src_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEL_W = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] src_sel,
    input  logic [WIDTH-1:0] data_rx,
    input  logic [WIDTH-1:0] data_IN,
    input  logic [WIDTH-1:0] data_SP,
    input  logic [WIDTH-1:0] data_T,
    input  logic [WIDTH-1:0] data_pc,
    input  logic [2:0]       imm3,
    input  logic [7:0]       imm8,
    input  logic [IDX_W-1:0] rx_idx,
    input  logic             ex_wr_en,
    input  logic [IDX_W-1:0] ex_wr_idx,
    input  logic [WIDTH-1:0] ex_wr_data,
    input  logic             mem_wr_en,
    input  logic [IDX_W-1:0] mem_wr_idx,
    input  logic [WIDTH-1:0] mem_wr_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] src,
    output logic             bad_sel
);

    logic             fwd_en;
    logic [WIDTH-1:0] rx_val;
    logic [WIDTH-1:0] sel_value;
    logic             sel_known;
    logic             capture;

`ifdef ALU_SRC_FWD_EN
    assign fwd_en = 1'b1;
`else
    assign fwd_en = 1'b0;
`endif

    alu_fwd_unit #(
        .WIDTH(WIDTH),
        .IDX_W(IDX_W)
    ) u_fwd (
        .en         (fwd_en),
        .ex_wr_en   (ex_wr_en),
        .ex_wr_idx  (ex_wr_idx),
        .ex_wr_data (ex_wr_data),
        .mem_wr_en  (mem_wr_en),
        .mem_wr_idx (mem_wr_idx),
        .mem_wr_data(mem_wr_data),
        .rx_idx     (rx_idx),
        .data_rx    (data_rx),
        .rx_val     (rx_val)
    );

    always_comb begin
        sel_value = '0;
        sel_known = 1'b1;
        case (src_sel)
            SEL_W'(SEL_ZERO):   sel_value = '0;
            SEL_W'(SEL_RX):     sel_value = rx_val;
            SEL_W'(SEL_Z_IMM3): sel_value = WIDTH'(imm3);
            SEL_W'(SEL_Z_IMM8): sel_value = WIDTH'(imm8);
            SEL_W'(SEL_IN):     sel_value = data_IN;
            SEL_W'(SEL_SP):     sel_value = data_SP;
            SEL_W'(SEL_T):      sel_value = data_T;
            SEL_W'(SEL_PC):     sel_value = data_pc;
            default:            sel_known = 1'b0;
        endcase
    end

    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            src       <= '0;
            bad_sel   <= 1'b0;
        end else begin
            // flush wins over a same-cycle capture; src is left as-is
            if (flush) begin
                out_valid <= 1'b0;
            end else if (capture) begin
                out_valid <= 1'b1;
                src       <= sel_value;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (capture && !flush && !sel_known) begin
                bad_sel <= 1'b1;
            end
        end
    end

endmodule

// File: doc/alu_src_stage.md
ALU_SRC_STAGE -- requirements
Module: alu_src_stage

Interface
Parameters:
REQ-001 SHALL have parameter WIDTH, default 16: operand/data width in bits.
REQ-002 SHALL have parameter SEL_W, default 8: source-select code width.
REQ-003 SHALL have parameter IDX_W, default 3: register index width.

Ports:
REQ-004 SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1: upstream request valid.
REQ-007 SHALL have port in_ready, output, 1: stage can accept a request this cycle.
REQ-008 SHALL have port src_sel, input, SEL_W: source code (ZERO, RX, Z_IMM3, Z_IMM8, IN, SP, T, PC).
REQ-009 SHALL have ports data_rx, data_IN, data_SP, data_T, data_pc, input, WIDTH each: candidate operand sources.
REQ-010 SHALL have ports imm3 (input, 3) and imm8 (input, 8): raw immediates.
REQ-011 SHALL have port rx_idx, input, IDX_W: register index behind data_rx.
REQ-012 SHALL have ports ex_wr_en (input, 1), ex_wr_idx (input, IDX_W) and ex_wr_data (input, WIDTH): EX-stage writeback bypass.
REQ-013 SHALL have ports mem_wr_en (input, 1), mem_wr_idx (input, IDX_W) and mem_wr_data (input, WIDTH): MEM-stage writeback bypass.
REQ-014 SHALL have port flush, input, 1: discard any held operand.
REQ-015 SHALL have port out_valid, output, 1: registered operand is valid.
REQ-016 SHALL have port out_ready, input, 1: downstream accepts the operand.
REQ-017 SHALL have port src, output, WIDTH: registered selected operand.
REQ-018 SHALL have port bad_sel, output, 1: sticky flag set on an unknown code.

Function
REQ-019 SHALL select, combinationally: ZERO->0; RX->data_rx (after forwarding); Z_IMM3/Z_IMM8->imm3/imm8 zero-extended to WIDTH; IN/SP/T/PC->the matching data_* port; any other code->0.
REQ-020 SHALL drive in_ready = !out_valid || out_ready, with no dependence on in_valid.
REQ-021 SHALL capture the selected value into src and set out_valid on the edge where in_valid && in_ready (latency 1 cycle).
REQ-022 SHALL clear out_valid when out_ready && out_valid and no new capture occurs in the same cycle; a capture in that same cycle keeps out_valid=1 with the new data.
REQ-023 SHALL hold src and out_valid stable while out_valid && !out_ready.
REQ-024 SHALL clear out_valid on the next edge when flush=1, overriding any simultaneous capture; src value is then don't-care.
REQ-025 SHALL set bad_sel on a captured request whose src_sel is unknown; bad_sel stays set until reset, and the captured src is 0.
REQ-026 SHALL evaluate forwarding only for RX: an EX match (ex_wr_en && ex_wr_idx==rx_idx) wins over a MEM match; with no match, use data_rx.
REQ-027 SHALL keep WIDTH-bit results, with no truncation beyond WIDTH and zero-extension only.

Reset
REQ-028 SHALL force out_valid=0, src=0 and bad_sel=0 immediately on rst=1, independent of clk, including mid-transfer.
REQ-029 SHALL drive in_ready=1 while out_valid=0 after reset.

Configuration
REQ-030 SHALL, with macro ALU_SRC_FWD_EN defined, implement the EX/MEM forwarding of REQ-026.
REQ-031 SHALL, without ALU_SRC_FWD_EN, use data_rx unmodified for RX; the bypass ports remain present and are ignored.

Structure
REQ-032 SHALL keep the select-code constants (ZERO=8'b00010000, RX=8'b00000101, Z_IMM3=8'b00010001, Z_IMM8=8'b00010010, IN=8'b00001000, SP=8'b00001001, T=8'b00001010, PC=8'b00010011) in a shared package, alu_src_pkg.
REQ-033 SHALL factor the forwarding compare/priority logic into one sub-module, alu_fwd_unit; selection and the pipeline register stay in alu_src_stage.

Verification
REQ-034 SHALL cover: reset mid-hold (out_valid=1, src=0x1234), assert rst between edges -> out_valid=0, src=0, bad_sel=0 at once.
REQ-035 SHALL cover: src_sel=Z_IMM8, imm8=0xA5, in_valid=1, out_ready=1 -> next edge src=0x00A5, out_valid=1.
REQ-036 SHALL cover: RX, rx_idx=2, ex hit 0x1111 and mem hit 0x2222 on idx 2 -> src=0x1111; without ALU_SRC_FWD_EN -> src=data_rx.
REQ-037 SHALL cover: out_ready=0 for 3 cycles with new in_valid requests -> in_ready=0, src unchanged; release -> next request captured.
REQ-038 SHALL cover: flush=1 with simultaneous in_valid=1 -> out_valid=0 next cycle.
REQ-039 SHALL cover: src_sel=8'hFF captured -> src=0, bad_sel=1, still 1 after later valid requests until rst.
